// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - op-class and forward-select constants shared by the decoder and the hazard unit
package hazard_pkg;

  // Op class of an instruction, as produced by the control decoder
  typedef enum logic [1:0] {
    HAZ_NONE  = 2'b00,
    HAZ_ALU   = 2'b01,
    HAZ_LOAD  = 2'b10,
    HAZ_STORE = 2'b11
  } haz_op_t;

  // Operand source selects for the ID-stage operands
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  // Only ALU ops and loads produce a register result worth forwarding
  function automatic logic is_writer(input haz_op_t op);
    return (op == HAZ_ALU) || (op == HAZ_LOAD);
  endfunction

endpackage

// File: rtl/hazard_detect_unit_if.sv
// rtl/hazard_detect_unit_if.sv - ID-stage hazard class in, pipeline control out
interface hazard_detect_unit_if;

  logic       rs1use;
  logic       rs2use;
  logic [1:0] hazard_optype;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic [4:0] rd_ID;
  logic       branch_taken_ID;

  logic       PC_EN_IF;
  logic       reg_FD_EN;
  logic       reg_FD_flush;
  logic       reg_DE_flush;
  logic [1:0] forward_ctrl_A;
  logic [1:0] forward_ctrl_B;
  logic       forward_ctrl_ls;

  // Core side: presents the ID instruction, consumes the controls
  modport master (
    output rs1use, rs2use, hazard_optype, rs1_ID, rs2_ID, rd_ID, branch_taken_ID,
    input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    input  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

  // Hazard unit side
  modport slave (
    input  rs1use, rs2use, hazard_optype, rs1_ID, rs2_ID, rd_ID, branch_taken_ID,
    output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
    output forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls
  );

endinterface

// File: rtl/hazard_detect_unit_fwd_select.sv
// rtl/hazard_detect_unit_fwd_select.sv - forward source select for one ID operand
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic       i_use,
  input  logic [4:0] i_ex_rd,
  input  haz_op_t    i_ex_op,
  input  logic [4:0] i_mem_rd,
  input  haz_op_t    i_mem_op,
  output logic [1:0] o_sel,
  output logic       o_ex_ld_match
);

  logic w_ex_match;
  logic w_mem_match;

  // x0 is never a dependency: it reads as zero regardless of any writer
  assign w_ex_match  = i_use & is_writer(i_ex_op)  & (i_ex_rd  == i_rs) & (i_rs != 5'd0);
  assign w_mem_match = i_use & is_writer(i_mem_op) & (i_mem_rd == i_rs) & (i_rs != 5'd0);

  // Load in EX has no data yet; the top turns this into a stall
  assign o_ex_ld_match = w_ex_match & (i_ex_op == HAZ_LOAD);

  // Youngest producer wins: EX ALU, then MEM ALU, then MEM load
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_match && (i_ex_op == HAZ_ALU)) begin
      o_sel = FWD_EX_ALU;
    end else if (w_mem_match && (i_mem_op == HAZ_ALU)) begin
      o_sel = FWD_MEM_ALU;
    end else if (w_mem_match && (i_mem_op == HAZ_LOAD)) begin
      o_sel = FWD_MEM_LD;
    end
  end

endmodule

// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - load-use stall, redirect flush and forwarding for the RV32I pipeline (option: HAZARD_PERF_EN)
module hazard_detect_unit
  import hazard_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  hazard_detect_unit_if.slave hif
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);

  haz_op_t    r_ex_op;
  haz_op_t    r_mem_op;
  logic [4:0] r_ex_rd;
  logic [4:0] r_mem_rd;

  haz_op_t    w_id_op;
  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_ld_a;
  logic       w_ld_b;
  logic       w_is_store;
  logic       w_store_bypass;
  logic       w_stall;

  assign w_id_op = haz_op_t'(hif.hazard_optype);

  fwd_select u_fwd_a (
    .i_rs          (hif.rs1_ID),
    .i_use         (hif.rs1use),
    .i_ex_rd       (r_ex_rd),
    .i_ex_op       (r_ex_op),
    .i_mem_rd      (r_mem_rd),
    .i_mem_op      (r_mem_op),
    .o_sel         (w_sel_a),
    .o_ex_ld_match (w_ld_a)
  );

  fwd_select u_fwd_b (
    .i_rs          (hif.rs2_ID),
    .i_use         (hif.rs2use),
    .i_ex_rd       (r_ex_rd),
    .i_ex_op       (r_ex_op),
    .i_mem_rd      (r_mem_rd),
    .i_mem_op      (r_mem_op),
    .o_sel         (w_sel_b),
    .o_ex_ld_match (w_ld_b)
  );

  // A store only needs rs2 as write data, which the core can take from the
  // load's WB value one stage later, so rs2-only load dependency skips the stall
  assign w_is_store     = (w_id_op == HAZ_STORE);
  assign w_store_bypass = rst_n & w_is_store & w_ld_b & ~w_ld_a;
  assign w_stall        = rst_n & (w_ld_a | (w_ld_b & ~w_is_store));

  // Pipeline controls; rst_n gating keeps the redirect quiet while in reset
  always_comb begin
    hif.PC_EN_IF        = ~w_stall;
    hif.reg_FD_EN       = ~w_stall;
    hif.reg_DE_flush    = w_stall;
    hif.reg_FD_flush    = rst_n & hif.branch_taken_ID & ~w_stall;
    hif.forward_ctrl_A  = rst_n ? w_sel_a : FWD_RF;
    hif.forward_ctrl_B  = (rst_n && !w_store_bypass) ? w_sel_b : FWD_RF;
    hif.forward_ctrl_ls = w_store_bypass;
  end

  // Shadow of EX/MEM destinations; a stall pushes a bubble into EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_rd  <= 5'd0;
      r_ex_op  <= HAZ_NONE;
      r_mem_rd <= 5'd0;
      r_mem_op <= HAZ_NONE;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_op <= r_ex_op;
      if (w_stall) begin
        r_ex_rd <= 5'd0;
        r_ex_op <= HAZ_NONE;
      end else begin
        r_ex_rd <= hif.rd_ID;
        if ((hif.rd_ID == 5'd0) || w_is_store) begin
          r_ex_op <= HAZ_NONE;
        end else begin
          r_ex_op <= w_id_op;
        end
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (hif.reg_FD_flush) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb/tb_hazard_detect_unit.sv - directed and random checks of hazard_detect_unit (option: HAZARD_PERF_EN)
module tb_hazard_detect_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_detect_unit_if hif();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_detect_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hif       (hif)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // In-flight instructions, youngest first: [0] is in EX, [1] is in MEM
  typedef struct {
    logic [4:0] rd;
    bit         wr;
    bit         ld;
  } rec_t;

  rec_t hist[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_stalls = 0;
  int   m_flushes = 0;
  bit   e_stall;
  bit   e_flush;
  rec_t e_next;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rec_t b;
    b = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
    hist.delete();
    hist.push_back(b);
    hist.push_back(b);
    m_stalls  = 0;
    m_flushes = 0;
    e_next    = b;
    e_stall   = 1'b0;
    e_flush   = 1'b0;
  endtask

  // 0 none, 1 EX alu, 2 EX load, 3 MEM alu, 4 MEM load (youngest writer of r)
  function automatic int producer(input logic [4:0] r);
    for (int a = 0; a < hist.size(); a++) begin
      if (hist[a].wr && hist[a].rd == r && r != 5'd0) return a * 2 + (hist[a].ld ? 2 : 1);
    end
    return 0;
  endfunction

  function automatic logic [1:0] fwd_of(input int p);
    case (p)
      1: return 2'b01;
      3: return 2'b10;
      4: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_en"}, hif.PC_EN_IF, 1);
    chk({tag, "_fd_en"}, hif.reg_FD_EN, 1);
    chk({tag, "_fd_flush"}, hif.reg_FD_flush, 0);
    chk({tag, "_de_flush"}, hif.reg_DE_flush, 0);
    chk({tag, "_fwdA"}, hif.forward_ctrl_A, 0);
    chk({tag, "_fwdB"}, hif.forward_ctrl_B, 0);
    chk({tag, "_ls"}, hif.forward_ctrl_ls, 0);
`ifdef HAZARD_PERF_EN
    chk({tag, "_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_flush_cnt"}, flush_cnt, 0);
`endif
  endtask

  task automatic drive(input bit u1, input bit u2, input logic [1:0] op,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input bit br);
    hif.rs1use          = u1;
    hif.rs2use          = u2;
    hif.hazard_optype   = op;
    hif.rs1_ID          = r1;
    hif.rs2_ID          = r2;
    hif.rd_ID           = rd;
    hif.branch_taken_ID = br;
  endtask

  // Present one ID instruction (entered at posedge+1) and check against the model
  task automatic cyc(input bit u1, input bit u2, input logic [1:0] op,
                     input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd, input bit br);
    int p1, p2;
    bit ld1, ld2, st, stl, ls;
    drive(u1, u2, op, r1, r2, rd, br);
    #3;
    p1  = producer(r1);
    p2  = producer(r2);
    ld1 = u1 && p1 == 2;
    ld2 = u2 && p2 == 2;
    st  = (op == 2'b11);
    stl = ld1 || (ld2 && !st);
    ls  = ld2 && st && !ld1;
    chk("pc_en", hif.PC_EN_IF, !stl);
    chk("fd_en", hif.reg_FD_EN, !stl);
    chk("de_flush", hif.reg_DE_flush, stl);
    chk("fd_flush", hif.reg_FD_flush, br && !stl);
    chk("ls", hif.forward_ctrl_ls, ls);
    if (!ld1) chk("fwdA", hif.forward_ctrl_A, u1 ? fwd_of(p1) : 2'b00);
    if (!ld2 || ls) chk("fwdB", hif.forward_ctrl_B, (ls || !u2) ? 2'b00 : fwd_of(p2));
    e_stall = stl;
    e_flush = br && !stl;
    if (stl) e_next = '{rd: 5'd0, wr: 1'b0, ld: 1'b0};
    else     e_next = '{rd: rd, wr: (rd != 5'd0) && (op == 2'b01 || op == 2'b10), ld: op == 2'b10};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      hist.push_front(e_next);
      hist.delete(hist.size() - 1);
      m_stalls  += int'(e_stall);
      m_flushes += int'(e_flush);
    end else begin
      model_reset();
    end
    #1;
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  localparam logic [1:0] N = 2'b00, A = 2'b01, L = 2'b10, S = 2'b11;

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1, 1, A, 5'd5, 5'd5, 5'd5, 1);
    #2;
    chk_reset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU chain: add x5,x1,x2 ; sub x6,x5,x3 ; and x9,x5,x4
    cyc(1, 1, A, 5'd1, 5'd2, 5'd5, 0); tick();
    cyc(1, 1, A, 5'd5, 5'd3, 5'd6, 0);
    chk("alu_chain_ex_fwdA", hif.forward_ctrl_A, 2'b01);
    chk("alu_chain_ex_pc_en", hif.PC_EN_IF, 1);
    tick();
    cyc(1, 1, A, 5'd5, 5'd4, 5'd9, 0);
    chk("alu_chain_mem_fwdA", hif.forward_ctrl_A, 2'b10);
    tick();

    // Load-use: lw x7,0(x1) ; add x8,x7,x2 (held one cycle)
    cyc(1, 0, L, 5'd1, 5'd0, 5'd7, 0); tick();
    cyc(1, 1, A, 5'd7, 5'd2, 5'd8, 0);
    chk("lu_stall_pc_en", hif.PC_EN_IF, 0);
    chk("lu_stall_fd_en", hif.reg_FD_EN, 0);
    chk("lu_stall_de_flush", hif.reg_DE_flush, 1);
    tick();
    cyc(1, 1, A, 5'd7, 5'd2, 5'd8, 0);
    chk("lu_after_fwdA", hif.forward_ctrl_A, 2'b11);
    chk("lu_after_pc_en", hif.PC_EN_IF, 1);
`ifdef HAZARD_PERF_EN
    chk("lu_stall_cnt", stall_cnt, 1);
`endif
    tick();

    // Load then store data: lw x7 ; sw x7,4(x2)
    cyc(1, 0, L, 5'd1, 5'd0, 5'd7, 0); tick();
    cyc(1, 1, S, 5'd2, 5'd7, 5'd4, 0);
    chk("ls_no_stall", hif.PC_EN_IF, 1);
    chk("ls_flag", hif.forward_ctrl_ls, 1);
    chk("ls_fwdB", hif.forward_ctrl_B, 2'b00);
    tick();

    // Load then store base: lw x7 ; sw x9,0(x7)
    cyc(1, 0, L, 5'd1, 5'd0, 5'd7, 0); tick();
    cyc(1, 1, S, 5'd7, 5'd9, 5'd0, 0);
    chk("st_base_stall", hif.PC_EN_IF, 0);
    chk("st_base_ls", hif.forward_ctrl_ls, 0);
    tick();
    cyc(1, 1, S, 5'd7, 5'd9, 5'd0, 0); tick();

    // x0 destination: addi x0,x0,1 ; add x3,x0,x0
    cyc(1, 0, A, 5'd0, 5'd0, 5'd0, 0); tick();
    cyc(1, 1, A, 5'd0, 5'd0, 5'd3, 0);
    chk("x0_fwdA", hif.forward_ctrl_A, 0);
    chk("x0_fwdB", hif.forward_ctrl_B, 0);
    tick();

    // Branch on load result: lw x7 ; beq x7,x1 (taken)
    cyc(1, 0, L, 5'd1, 5'd0, 5'd7, 0); tick();
    cyc(1, 1, N, 5'd7, 5'd1, 5'd0, 1);
    chk("br_stall_pc_en", hif.PC_EN_IF, 0);
    chk("br_stall_fd_flush", hif.reg_FD_flush, 0);
    tick();
    cyc(1, 1, N, 5'd7, 5'd1, 5'd0, 1);
    chk("br_taken_fd_flush", hif.reg_FD_flush, 1);
    tick();
`ifdef HAZARD_PERF_EN
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_stall_cnt", stall_cnt, 3);
`endif

    // Reset during a stall
    cyc(1, 0, L, 5'd1, 5'd0, 5'd7, 0); tick();
    cyc(1, 1, A, 5'd7, 5'd2, 5'd8, 1);
    chk("rst_pre_stall", hif.PC_EN_IF, 0);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid_stall");
    tick();
    rst_n = 1'b1;
    cyc(1, 1, A, 5'd7, 5'd2, 5'd8, 0);
    chk("rst_after_fwdA", hif.forward_ctrl_A, 0);
    chk("rst_after_pc_en", hif.PC_EN_IF, 1);
    tick();

    // Random traffic over a small register window to force collisions
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
